// File: rtl/usb2_pkg.sv
// Shared USB 2.0 endpoint-0 definitions: PID nibbles, engine states,
// receive buffer depth.
package usb2_pkg;

    localparam logic [3:0] PID_OUT   = 4'hE;
    localparam logic [3:0] PID_IN    = 4'h6;
    localparam logic [3:0] PID_SETUP = 4'h2;
    localparam logic [3:0] PID_SOF   = 4'hA;
    localparam logic [3:0] PID_ACK   = 4'hD;
    localparam logic [3:0] PID_NAK   = 4'h5;
    localparam logic [3:0] PID_DATA0 = 4'hC;
    localparam logic [3:0] PID_DATA1 = 4'h4;

    localparam int EP0_BUF_DEPTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_RX_HS,
        ST_TX_WAIT,
        ST_TX_DATA,
        ST_TX_END,
        ST_HS_WAIT
    } ep0_state_e;

    function automatic logic is_data_pid(input logic [3:0] p);
        return (p == PID_DATA0) || (p == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb2_ep0_xfer.sv
// Endpoint-0 transaction engine: token match, OUT/SETUP payload capture,
// IN response streaming with DATA0/DATA1 toggle and handshakes.
module usb2_ep0_xfer
    import usb2_pkg::*;
#(
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT_CYC = 800
) (
    input  logic       phy_clk,
    input  logic       reset,
    input  logic       tok_valid,
    input  logic [3:0] tok_pid,
    input  logic [6:0] tok_addr,
    input  logic [3:0] tok_endp,
    input  logic [6:0] dev_addr,
    input  logic       rx_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic [3:0] rx_pid,
    input  logic       rx_done,
    input  logic       rx_crc_ok,
    output logic       tx_start,
    output logic [3:0] tx_pid,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ack,
    input  logic       tx_done,
    output logic       xfer_in,
    output logic       xfer_out,
    output logic [3:0] xfer_pid,
    input  logic       xfer_ready,
    output logic [5:0] buf_in_addr,
    output logic [7:0] buf_in_data,
    output logic       buf_in_wren,
    output logic [7:0] buf_out_addr,
    input  logic [7:0] buf_out_q,
    input  logic [5:0] buf_out_len
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int LW = $clog2(RD_LAT + 1) + 1;

    ep0_state_e state_q, state_d;
    logic          toggle_q, toggle_d;
    logic          xin_q, xin_d;
    logic          xout_q, xout_d;
    logic [3:0]    xpid_q, xpid_d;
    logic [6:0]    idx_q, idx_d;
    logic          seen_q, seen_d;
    logic          dpid_ok_q, dpid_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          txs_q, txs_d;
    logic [3:0]    txpid_q, txpid_d;
    logic          txv_q, txv_d;
    logic [7:0]    txdat_q, txdat_d;
    logic          wren_q, wren_d;
    logic [5:0]    waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    raddr_q, raddr_d;

    logic tok_hit;
    logic tmo_hit;
    logic pid_ok_now;
    logic [7:0] len8;
    logic [7:0] raddr_nx;

    assign tok_hit    = tok_valid && (tok_addr == dev_addr) && (tok_endp == 4'd0);
    assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign pid_ok_now = rx_active ? is_data_pid(rx_pid) : dpid_ok_q;
    assign len8       = {2'b00, buf_out_len};
    assign raddr_nx   = raddr_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        toggle_d  = toggle_q;
        xin_d     = xin_q;
        xout_d    = xout_q;
        xpid_d    = xpid_q;
        idx_d     = idx_q;
        seen_d    = seen_q;
        dpid_ok_d = dpid_ok_q;
        tmo_d     = tmo_q;
        lat_d     = lat_q;
        txs_d     = 1'b0;
        txpid_d   = txpid_q;
        txv_d     = txv_q;
        txdat_d   = txdat_q;
        wren_d    = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        raddr_d   = raddr_q;

        case (state_q)
            ST_IDLE: begin
                if (tok_hit) begin
                    case (tok_pid)
                        PID_SETUP, PID_OUT: begin
                            xin_d     = 1'b1;
                            xpid_d    = tok_pid;
                            idx_d     = '0;
                            seen_d    = 1'b0;
                            dpid_ok_d = 1'b0;
                            tmo_d     = '0;
                            state_d   = ST_RX_DATA;
                        end
                        PID_IN: begin
                            xout_d  = 1'b1;
                            xpid_d  = tok_pid;
                            tmo_d   = '0;
                            state_d = ST_TX_WAIT;
                        end
                        default: ;
                    endcase
                end
            end

            ST_RX_DATA: begin
                if (rx_active) begin
                    seen_d    = 1'b1;
                    dpid_ok_d = is_data_pid(rx_pid);
                end
                // index saturates at the buffer depth; excess bytes are dropped
                if (rx_valid && (idx_q < 7'(EP0_BUF_DEPTH))) begin
                    wren_d  = 1'b1;
                    waddr_d = idx_q[5:0];
                    wdata_d = rx_data;
                    idx_d   = idx_q + 7'd1;
                end
                if (!seen_q && !rx_active) begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (rx_done) begin
                    xin_d = 1'b0;
                    if (!rx_crc_ok || !pid_ok_now) begin
                        state_d = ST_IDLE;
                    end else if (xpid_q == PID_SETUP) begin
                        txs_d    = 1'b1;
                        txpid_d  = PID_ACK;
                        toggle_d = 1'b1;
                        state_d  = ST_RX_HS;
                    end else if (xfer_ready) begin
                        txs_d    = 1'b1;
                        txpid_d  = PID_ACK;
                        toggle_d = ~toggle_q;
                        state_d  = ST_RX_HS;
                    end else begin
                        txs_d   = 1'b1;
                        txpid_d = PID_NAK;
                        state_d = ST_RX_HS;
                    end
                end else if (!seen_q && !rx_active && tmo_hit) begin
                    xin_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_RX_HS: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end

            ST_TX_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_q == TW'(1)) begin
                    tmo_d = '0;
                    txs_d = 1'b1;
                    if (xfer_ready) begin
                        txpid_d = toggle_q ? PID_DATA1 : PID_DATA0;
                        raddr_d = '0;
                        lat_d   = '0;
                        state_d = ST_TX_DATA;
                    end else begin
                        txpid_d = PID_NAK;
                        xout_d  = 1'b0;
                        state_d = ST_RX_HS;
                    end
                end
            end

            ST_TX_DATA: begin
                if (txv_q) begin
                    if (tx_ack) begin
                        txv_d   = 1'b0;
                        raddr_d = raddr_nx;
                        lat_d   = '0;
                        if (raddr_nx >= len8) begin
                            state_d = ST_TX_END;
                        end
                    end
                end else if (lat_q != LW'(RD_LAT)) begin
                    lat_d = lat_q + LW'(1);
                end else if (raddr_q < len8) begin
                    txv_d   = 1'b1;
                    txdat_d = buf_out_q;
                end else begin
                    state_d = ST_TX_END;
                end
            end

            ST_TX_END: begin
                if (tx_done) begin
                    tmo_d   = '0;
                    state_d = ST_HS_WAIT;
                end
            end

            ST_HS_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // a missing or wrong handshake keeps the toggle for retransmit
                if (tok_valid) begin
                    if (tok_pid == PID_ACK) begin
                        toggle_d = ~toggle_q;
                    end
                    xout_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    xout_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            toggle_q  <= 1'b0;
            xin_q     <= 1'b0;
            xout_q    <= 1'b0;
            xpid_q    <= '0;
            idx_q     <= '0;
            seen_q    <= 1'b0;
            dpid_ok_q <= 1'b0;
            tmo_q     <= '0;
            lat_q     <= '0;
            txs_q     <= 1'b0;
            txpid_q   <= '0;
            txv_q     <= 1'b0;
            txdat_q   <= '0;
            wren_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            toggle_q  <= toggle_d;
            xin_q     <= xin_d;
            xout_q    <= xout_d;
            xpid_q    <= xpid_d;
            idx_q     <= idx_d;
            seen_q    <= seen_d;
            dpid_ok_q <= dpid_ok_d;
            tmo_q     <= tmo_d;
            lat_q     <= lat_d;
            txs_q     <= txs_d;
            txpid_q   <= txpid_d;
            txv_q     <= txv_d;
            txdat_q   <= txdat_d;
            wren_q    <= wren_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            raddr_q   <= raddr_d;
        end
    end

    assign tx_start     = txs_q;
    assign tx_pid       = txpid_q;
    assign tx_valid     = txv_q;
    assign tx_data      = txdat_q;
    assign xfer_in      = xin_q;
    assign xfer_out     = xout_q;
    assign xfer_pid     = xpid_q;
    assign buf_in_addr  = waddr_q;
    assign buf_in_data  = wdata_q;
    assign buf_in_wren  = wren_q;
    assign buf_out_addr = raddr_q;

endmodule

// File: tb/tb_usb2_ep0_xfer.sv
// Directed bench for usb2_ep0_xfer: token filter table plus SETUP/IN/OUT,
// timeout, truncation and reset sequences.
module tb_usb2_ep0_xfer;

    localparam logic [3:0] T_OUT = 4'hE, T_IN = 4'h6, T_SETUP = 4'h2;
    localparam logic [3:0] T_SOF = 4'hA, T_ACK = 4'hD, T_NAK = 4'h5;
    localparam logic [3:0] T_D0 = 4'hC, T_D1 = 4'h4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tok_valid = 0;
    logic [3:0] tok_pid = 0;
    logic [6:0] tok_addr = 0;
    logic [3:0] tok_endp = 0;
    logic [6:0] dev_addr = 0;
    logic       rx_active = 0, rx_valid = 0, rx_done = 0, rx_crc_ok = 0;
    logic [7:0] rx_data = 0;
    logic [3:0] rx_pid = 0;
    logic       tx_start, tx_valid, tx_ack = 0, tx_done = 0;
    logic [3:0] tx_pid;
    logic [7:0] tx_data;
    logic       xfer_in, xfer_out, xfer_ready = 0;
    logic [3:0] xfer_pid;
    logic [5:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren;
    logic [7:0] buf_out_addr;
    logic [7:0] buf_out_q = 0;
    logic [5:0] buf_out_len = 0;

    usb2_ep0_xfer #(.RD_LAT(2), .TIMEOUT_CYC(800)) dut (
        .phy_clk(clk), .reset(reset),
        .tok_valid(tok_valid), .tok_pid(tok_pid),
        .tok_addr(tok_addr), .tok_endp(tok_endp), .dev_addr(dev_addr),
        .rx_active(rx_active), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_pid(rx_pid), .rx_done(rx_done), .rx_crc_ok(rx_crc_ok),
        .tx_start(tx_start), .tx_pid(tx_pid), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ack(tx_ack), .tx_done(tx_done),
        .xfer_in(xfer_in), .xfer_out(xfer_out), .xfer_pid(xfer_pid),
        .xfer_ready(xfer_ready),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data),
        .buf_in_wren(buf_in_wren),
        .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q),
        .buf_out_len(buf_out_len)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int wr_cnt = 0, ts_cnt = 0, nbytes = 0, addr_chg = 0;
    logic [7:0] mem [64];
    logic [7:0] txb [128];
    logic [7:0] prev_addr = 0;
    logic [7:0] p1 = 0;

    // response buffer: content = addr ^ 5A, two-cycle read latency
    always @(posedge clk) begin
        p1 <= buf_out_addr ^ 8'h5A;
        buf_out_q <= p1;
    end

    always @(negedge clk) begin
        if (buf_in_wren) begin
            mem[buf_in_addr] = buf_in_data;
            wr_cnt++;
        end
        if (tx_start) ts_cnt++;
        if (tx_valid && !tx_ack) begin
            if (nbytes < 128) txb[nbytes] = tx_data;
            nbytes++;
            tx_ack = 1'b1;
        end else begin
            tx_ack = 1'b0;
        end
        if (buf_out_addr != prev_addr) addr_chg++;
        prev_addr = buf_out_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_tok(input logic [3:0] p, input logic [6:0] a,
                            input logic [3:0] e);
        tok_valid = 1; tok_pid = p; tok_addr = a; tok_endp = e;
        tick();
        tok_valid = 0;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        rx_active = 1; rx_pid = T_D0;
        for (int i = 0; i < n; i++) begin
            rx_valid = 1; rx_data = base + 8'(i);
            tick();
        end
        rx_valid = 0; rx_active = 0;
        tick();
    endtask

    task automatic pulse_done();
        tx_done = 1;
        tick();
        tx_done = 0;
    endtask

    task automatic wait_start(input string nm, input int lim);
        bit got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            if (tx_start) got = 1;
            else tick();
        end
        chk({nm, "_start_seen"}, got, 1);
    endtask

    task automatic wait_bytes(input string nm, input int n, input int lim);
        for (int i = 0; i < lim && nbytes < n; i++) tick();
        chk({nm, "_bytes"}, nbytes, n);
    endtask

    typedef struct {
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic [6:0] dev;
        logic       exp_in;
        logic       exp_out;
    } tok_vec_t;

    tok_vec_t vt [9];

    initial begin
        int s0, w0, n0, a0;
        vt[0] = '{T_SETUP, 7'd0, 4'd0, 7'd0, 1, 0};
        vt[1] = '{T_OUT,   7'd0, 4'd0, 7'd0, 1, 0};
        vt[2] = '{T_IN,    7'd0, 4'd0, 7'd0, 0, 1};
        vt[3] = '{T_OUT,   7'd5, 4'd0, 7'd0, 0, 0};
        vt[4] = '{T_SOF,   7'd0, 4'd0, 7'd0, 0, 0};
        vt[5] = '{T_IN,    7'd0, 4'd1, 7'd0, 0, 0};
        vt[6] = '{T_SETUP, 7'd7, 4'd0, 7'd7, 1, 0};
        vt[7] = '{T_IN,    7'd7, 4'd0, 7'd0, 0, 0};
        vt[8] = '{T_ACK,   7'd0, 4'd0, 7'd0, 0, 0};

        ticks(3);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_xfer", {xfer_in, xfer_out, xfer_pid}, 0);
        chk("rst_wren", buf_in_wren, 0);
        reset = 0;
        ticks(2);

        for (int k = 0; k < 9; k++) begin
            dev_addr = vt[k].dev;
            xfer_ready = 0;
            s0 = ts_cnt;
            send_tok(vt[k].pid, vt[k].addr, vt[k].endp);
            chk($sformatf("tbl%0d_xin", k), xfer_in, vt[k].exp_in);
            chk($sformatf("tbl%0d_xout", k), xfer_out, vt[k].exp_out);
            if (vt[k].exp_in || vt[k].exp_out)
                chk($sformatf("tbl%0d_pid", k), xfer_pid, vt[k].pid);
            if (vt[k].exp_in) begin
                rx_done = 1; rx_crc_ok = 0;
                tick();
                rx_done = 0;
                chk($sformatf("tbl%0d_xin_clr", k), xfer_in, 0);
            end else if (vt[k].exp_out) begin
                wait_start($sformatf("tbl%0d", k), 10);
                chk($sformatf("tbl%0d_nak", k), tx_pid, T_NAK);
                pulse_done();
            end else begin
                ticks(5);
                chk($sformatf("tbl%0d_quiet", k), ts_cnt, s0);
            end
            ticks(2);
        end
        dev_addr = 0;

        // SETUP with 8 data + 2 CRC bytes
        xfer_ready = 0;
        w0 = wr_cnt;
        send_tok(T_SETUP, 0, 0);
        chk("setup_xin", xfer_in, 1);
        send_bytes(10, 8'h10);
        chk("setup_xin_pre", xfer_in, 1);
        rx_done = 1; rx_crc_ok = 1;
        tick();
        rx_done = 0;
        chk("setup_xin_fall", xfer_in, 0);
        chk("setup_hs_start", tx_start, 1);
        chk("setup_hs_pid", tx_pid, T_ACK);
        tick();
        pulse_done();
        chk("setup_wr_cnt", wr_cnt - w0, 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("setup_mem%0d", i), mem[i], 8'h10 + 8'(i));

        // IN, 18 bytes, expect DATA1 after SETUP
        xfer_ready = 1; buf_out_len = 18; nbytes = 0;
        send_tok(T_IN, 0, 0);
        chk("in1_xout", xfer_out, 1);
        chk("in1_pid", xfer_pid, T_IN);
        chk("in1_ts_c1", tx_start, 0);
        tick();
        chk("in1_ts_c2", tx_start, 0);
        tick();
        chk("in1_ts_c3", tx_start, 1);
        chk("in1_data1", tx_pid, T_D1);
        ticks(2);
        chk("in1_tv_early", tx_valid, 0);
        tick();
        chk("in1_tv_first", tx_valid, 1);
        wait_bytes("in1", 18, 300);
        for (int i = 0; i < 18; i++)
            chk($sformatf("in1_byte%0d", i), txb[i], 8'(i) ^ 8'h5A);
        ticks(2);
        pulse_done();
        chk("in1_xout_hs", xfer_out, 1);
        send_tok(T_ACK, 0, 0);
        chk("in1_xout_ack", xfer_out, 0);

        // zero-length IN, toggle now 0; no ACK -> timeout
        buf_out_len = 0; n0 = nbytes;
        send_tok(T_IN, 0, 0);
        wait_start("zlp", 10);
        chk("zlp_data0", tx_pid, T_D0);
        ticks(6);
        chk("zlp_nobytes", nbytes, n0);
        pulse_done();
        ticks(790);
        chk("tmo_xout_hold", xfer_out, 1);
        ticks(20);
        chk("tmo_xout_clr", xfer_out, 0);

        // retransmit keeps DATA0
        buf_out_len = 1;
        send_tok(T_IN, 0, 0);
        wait_start("retx", 10);
        chk("retx_data0", tx_pid, T_D0);
        wait_bytes("retx", n0 + 1, 50);
        ticks(2);
        pulse_done();
        send_tok(T_ACK, 0, 0);
        chk("retx_xout_ack", xfer_out, 0);

        // IN while not ready -> NAK, no reads
        xfer_ready = 0; a0 = addr_chg; n0 = nbytes;
        send_tok(T_IN, 0, 0);
        ticks(2);
        chk("nak_start", tx_start, 1);
        chk("nak_pid", tx_pid, T_NAK);
        chk("nak_xout", xfer_out, 0);
        pulse_done();
        ticks(3);
        chk("nak_no_reads", addr_chg, a0);
        chk("nak_no_bytes", nbytes, n0);

        // OUT with bad CRC -> no handshake
        xfer_ready = 1; s0 = ts_cnt;
        send_tok(T_OUT, 0, 0);
        chk("obad_xin", xfer_in, 1);
        send_bytes(4, 8'h30);
        rx_done = 1; rx_crc_ok = 0;
        tick();
        rx_done = 0;
        chk("obad_xin_clr", xfer_in, 0);
        ticks(8);
        chk("obad_no_hs", ts_cnt, s0);

        // toggle still 1: DATA1; SOF in HS_WAIT keeps the toggle
        buf_out_len = 0;
        send_tok(T_IN, 0, 0);
        wait_start("in_d1", 10);
        chk("in_d1_pid", tx_pid, T_D1);
        ticks(6);
        pulse_done();
        tick();
        send_tok(T_SOF, 0, 0);
        chk("sof_xout_clr", xfer_out, 0);

        // OUT of 70 bytes: only 0..63 written, ACK flips toggle to 0
        w0 = wr_cnt;
        send_tok(T_OUT, 0, 0);
        send_bytes(70, 8'hA0);
        rx_done = 1; rx_crc_ok = 1;
        tick();
        rx_done = 0;
        chk("o70_start", tx_start, 1);
        chk("o70_ack", tx_pid, T_ACK);
        tick();
        pulse_done();
        chk("o70_wr_cnt", wr_cnt - w0, 64);
        chk("o70_mem0", mem[0], 8'hA0);
        chk("o70_mem63", mem[63], 8'hDF);

        // IN with DATA0, then reset mid TX_DATA
        buf_out_len = 5; n0 = nbytes;
        send_tok(T_IN, 0, 0);
        wait_start("rst_in", 10);
        chk("rst_in_data0", tx_pid, T_D0);
        wait_bytes("rst_in", n0 + 2, 50);
        reset = 1;
        #1;
        chk("midrst_xfer", {xfer_in, xfer_out, xfer_pid}, 0);
        chk("midrst_tx", {tx_start, tx_valid, tx_pid, tx_data}, 0);
        chk("midrst_buf", {buf_out_addr, buf_in_wren, buf_in_addr}, 0);
        ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
